fifo_sync_handshake: RTL and testbench



---
 rtl/fifo_sync_handshake.sv | 81 ++++++++
 tb/tb_fifo_sync_handshake.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_handshake.sv
// Single-clock FIFO with ready/enable handshake on both sides and first-word fall-through output.
// Optional sticky overflow flag enabled by defining FIFO_SYNC_OVERFLOW_FLAG_EN.
module fifo_sync_handshake #(
    parameter int unsigned width = 48,
    parameter int unsigned depth = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [width-1:0]         in_data,
    input  logic                     in_enable,
    output logic                     in_ready,
    output logic [width-1:0]         out_data,
    output logic                     out_enable,
    input  logic                     out_ready,
    output logic [$clog2(depth):0]   count,
    output logic                     overflow
);

    localparam int unsigned ptr_w = $clog2(depth);
    localparam int unsigned cnt_w = ptr_w + 1;

    logic [width-1:0] mem [depth];
    logic [ptr_w-1:0] wptr;
    logic [ptr_w-1:0] rptr;
    logic             wr_beat;
    logic             rd_beat;

    // Handshake flags derive only from registered state (plus reset), never from the peer's inputs
    always_comb begin
        in_ready   = !reset && (count != cnt_w'(depth));
        out_enable = (count != cnt_w'(0));
        out_data   = mem[rptr];
        wr_beat    = in_enable && in_ready;
        rd_beat    = out_ready && out_enable;
    end

    // Pointers wrap naturally because depth is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_beat) begin
                wptr <= wptr + ptr_w'(1);
            end
            if (rd_beat) begin
                rptr <= rptr + ptr_w'(1);
            end
            case ({wr_beat, rd_beat})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; contents are meaningless until written
    always_ff @(posedge clk) begin
        if (wr_beat) begin
            mem[wptr] <= in_data;
        end
    end

`ifdef FIFO_SYNC_OVERFLOW_FLAG_EN
    // Sticky: any refused write attempt latches the flag until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (in_enable && !in_ready) begin
            overflow <= 1'b1;
`ifndef SYNTHESIS
            $display("%0t %m: write refused, FIFO full", $time);
`endif
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_handshake.sv
// Directed self-checking bench for fifo_sync_handshake (width 48, depth 4).
module tb_fifo_sync_handshake;

    localparam int unsigned width = 48;
    localparam int unsigned depth = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [width-1:0]  in_data;
    logic              in_enable;
    logic              in_ready;
    logic [width-1:0]  out_data;
    logic              out_enable;
    logic              out_ready;
    logic [2:0]        count;
    logic              overflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [width-1:0] words [5];
    logic [width-1:0] held;
    logic             ovf_exp;

    fifo_sync_handshake #(.width(width), .depth(depth)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_enable  (in_enable),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_enable (out_enable),
        .out_ready  (out_ready),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef FIFO_SYNC_OVERFLOW_FLAG_EN
        ovf_exp = 1'b1;
`else
        ovf_exp = 1'b0;
`endif
        words[0] = 48'hAAAA_0000_0001;
        words[1] = 48'hBBBB_0000_0002;
        words[2] = 48'hCCCC_0000_0003;
        words[3] = 48'hDDDD_0000_0004;
        words[4] = 48'hEEEE_0000_0005;

        reset     = 1'b1;
        in_data   = '0;
        in_enable = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready",   64'(in_ready),   64'd0);
        check("rst_out_enable", 64'(out_enable), 64'd0);
        check("rst_count",      64'(count),      64'd0);
        reset = 1'b0;
        tick();
        check("idle_in_ready",   64'(in_ready),   64'd1);
        check("idle_out_enable", 64'(out_enable), 64'd0);
        check("idle_count",      64'(count),      64'd0);
        check("idle_overflow",   64'(overflow),   64'd0);

        // Single word with fall-through, then held while consumer stalls
        in_data   = 48'h000001_000002;
        in_enable = 1'b1;
        tick();
        in_enable = 1'b0;
        check("one_out_enable", 64'(out_enable), 64'd1);
        check("one_out_data",   64'(out_data),   64'h0000_0001_0000_02);
        check("one_count",      64'(count),      64'd1);
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_data",  64'(out_data), 64'h0000_0001_0000_02);
            check("hold_count", 64'(count),    64'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("one_drained_en",    64'(out_enable), 64'd0);
        check("one_drained_count", 64'(count),      64'd0);

        // Fill to full
        for (int i = 0; i < 4; i++) begin
            in_data   = words[i];
            in_enable = 1'b1;
            tick();
        end
        check("full_count",    64'(count),    64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_overflow_pre", 64'(overflow), 64'd0);

        // Fifth write refused
        in_data = words[4];
        tick();
        check("refused_count", 64'(count),    64'd4);
        check("refused_head",  64'(out_data), 64'(words[0]));
        check("overflow_set",  64'(overflow), 64'(ovf_exp));

        // Read while full with write pending: write still refused that edge
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("rw_full_count",    64'(count),    64'd3);
        check("rw_full_in_ready", 64'(in_ready), 64'd1);
        check("rw_full_head",     64'(out_data), 64'(words[1]));
        tick();
        in_enable = 1'b0;
        check("refill_count", 64'(count), 64'd4);

        // Drain in order: B, C, D, E
        for (int i = 1; i < 5; i++) begin
            check("drain_en",   64'(out_enable), 64'd1);
            check("drain_data", 64'(out_data),   64'(words[i]));
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        check("drained_en",    64'(out_enable), 64'd0);
        check("drained_count", 64'(count),      64'd0);
        check("overflow_sticky", 64'(overflow), 64'(ovf_exp));

        // Streaming: one word per cycle, one-cycle latency, pointers wrap
        out_ready = 1'b1;
        in_enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 48'(64'h1000 + 64'(i));
            tick();
            check("stream_data",  64'(out_data),   64'h1000 + 64'(i));
            check("stream_count", 64'(count),      64'd1);
            check("stream_ready", 64'(in_ready),   64'd1);
        end
        in_enable = 1'b0;
        tick();
        out_ready = 1'b0;
        check("stream_end_count", 64'(count),      64'd0);
        check("stream_end_en",    64'(out_enable), 64'd0);

        // Asynchronous reset mid-cycle with three words stored
        for (int i = 0; i < 3; i++) begin
            in_data   = words[i];
            in_enable = 1'b1;
            tick();
        end
        in_enable = 1'b0;
        check("pre_rst_count", 64'(count), 64'd3);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_en",       64'(out_enable), 64'd0);
        check("async_rst_ready",    64'(in_ready),   64'd0);
        check("async_rst_count",    64'(count),      64'd0);
        check("async_rst_overflow", 64'(overflow),   64'd0);
        tick();
        reset = 1'b0;
        in_data   = 48'h1234_5678_9ABC;
        in_enable = 1'b1;
        tick();
        in_enable = 1'b0;
        check("post_rst_en",    64'(out_enable), 64'd1);
        check("post_rst_data",  64'(out_data),   64'h1234_5678_9ABC);
        check("post_rst_count", 64'(count),      64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
